// File: rtl/pinbus_responder.sv
// Responder for the pin-level req/ack bus: synchronizes the host strobe, runs a
// four-phase handshake and owns a small byte register file exported flat.
module pinbus_responder #(
    parameter int          DEPTH       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  RESET_VAL   = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [7:0]         ui_in,
    input  logic [7:0]         uio_in,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe,
    output logic               ack,
    output logic               err,
    output logic [8*DEPTH-1:0] regs_flat
);

    // state    | meaning
    // IDLE     | waiting for a synchronized request while ena is high
    // WR_ACK   | register written on entry, ack raised
    // RD_DRIVE | read data on the pins, ack still low (bus turnaround)
    // WAIT_LOW | ack held high until the host drops req
    typedef enum logic [1:0] {IDLE, WR_ACK, RD_DRIVE, WAIT_LOW} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [7:0]             regs [DEPTH];
    logic [7:0]             rd_data;
    logic                   addr_hit;
    logic                   wr_en, err_set;
    logic                   ack_n, oe_q, oe_n;
    logic [7:0]             dout_q, dout_n;
    logic                   unused_bits;

    assign unused_bits = ^ui_in[5:3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], ui_in[7]};
    end
    assign req_s = sync_q[SYNC_STAGES-1];

    // rw/addr/data are consumed only on the IDLE exit edge, where the host
    // guarantees them stable, so they are used straight from the pins.
    always_comb begin
        rd_data  = 8'h00;
        addr_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ui_in[2:0] == 3'(i)) begin
                rd_data  = regs[i];
                addr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        wr_en   = 1'b0;
        err_set = 1'b0;
        ack_n   = ack;
        oe_n    = oe_q;
        dout_n  = dout_q;
        case (state)
            IDLE: begin
                if (req_s && ena) begin
                    err_set = !addr_hit;
                    if (ui_in[6]) begin
                        state_n = WR_ACK;
                        wr_en   = addr_hit;
                        ack_n   = 1'b1;
                    end else begin
                        state_n = RD_DRIVE;
                        oe_n    = 1'b1;
                        dout_n  = rd_data;
                    end
                end
            end
            WR_ACK: state_n = WAIT_LOW;
            RD_DRIVE: begin
                state_n = WAIT_LOW;
                ack_n   = 1'b1;
            end
            WAIT_LOW: begin
                if (!req_s) begin
                    state_n = IDLE;
                    ack_n   = 1'b0;
                    oe_n    = 1'b0;
                    dout_n  = 8'h00;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ack    <= 1'b0;
            oe_q   <= 1'b0;
            dout_q <= 8'h00;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            ack    <= ack_n;
            oe_q   <= oe_n;
            dout_q <= dout_n;
            if (err_set) err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && ui_in[2:0] == 3'(i)) regs[i] <= uio_in;
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < DEPTH; i++) regs_flat[8*i +: 8] = regs[i];
    end

    assign uio_out = dout_q;
    assign uio_oe  = {8{oe_q}};

endmodule

// File: tb/tb_pinbus_responder.sv
// Self-checking bench: a DEPTH=8 and a DEPTH=4 responder share one host bus and
// are checked against a transaction-level register-file model.
module tb_pinbus_responder;

    logic        clk = 1'b0;
    logic        rst_n, ena;
    logic [7:0]  ui_in, uio_in;
    logic [7:0]  uio_out8, uio_oe8, uio_out4, uio_oe4;
    logic        ack8, err8, ack4, err4;
    logic [63:0] regs_flat8;
    logic [31:0] regs_flat4;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] m8 [8];
    logic [7:0] m4 [4];
    logic       e8, e4;

    typedef struct {
        logic       rw;
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] exp8;
        logic [7:0] exp4;
        logic       experr4;
    } vec_t;
    vec_t tbl [9];

    always #5 clk = ~clk;

    pinbus_responder u_dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uio_out(uio_out8), .uio_oe(uio_oe8), .ack(ack8), .err(err8),
        .regs_flat(regs_flat8)
    );

    pinbus_responder #(.DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uio_out(uio_out4), .uio_oe(uio_oe4), .ack(ack4), .err(err4),
        .regs_flat(regs_flat4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m8[i] = 8'h00;
        for (int i = 0; i < 4; i++) m4[i] = 8'h00;
        e8 = 1'b0;
        e4 = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        logic [63:0] x8;
        logic [31:0] x4;
        for (int i = 0; i < 8; i++) x8[8*i +: 8] = m8[i];
        for (int i = 0; i < 4; i++) x4[8*i +: 8] = m4[i];
        chk({tag, " regs8"}, regs_flat8, x8);
        chk({tag, " regs4"}, {32'h0, regs_flat4}, {32'h0, x4});
        chk({tag, " err8"}, {63'h0, err8}, {63'h0, e8});
        chk({tag, " err4"}, {63'h0, err4}, {63'h0, e4});
    endtask

    // Full four-phase transaction with latency checks; updates the model.
    task automatic do_txn(input logic rw, input logic [2:0] a, input logic [7:0] d,
                          input int hold, input bit drop_ena,
                          output logic [7:0] rd8, output logic [7:0] rd4);
        int ack_lat, oe_lat, rel_lat;
        logic [7:0] x8, x4, prev_oe;
        bit held_ok;
        x8 = m8[a];
        x4 = (a < 4) ? m4[a[1:0]] : 8'h00;
        rd8 = 8'h00;
        rd4 = 8'h00;
        @(negedge clk);
        ui_in  = {1'b1, rw, 3'($urandom_range(0, 7)), a};
        uio_in = d;
        ack_lat = -1;
        oe_lat  = -1;
        for (int k = 1; k <= 12 && ack_lat < 0; k++) begin
            @(posedge clk); #1;
            if (k == 3 && drop_ena) ena = 1'b0;
            if (oe_lat < 0 && uio_oe8 == 8'hFF) begin
                oe_lat = k;
                rd8 = uio_out8;
                rd4 = uio_out4;
            end
            if (ack8) ack_lat = k;
        end
        chk("ack latency", 64'(ack_lat), rw ? 64'd3 : 64'd4);
        chk("ack4 matches", {63'h0, ack4}, 64'd1);
        if (!rw) begin
            chk("oe latency", 64'(oe_lat), 64'd3);
            chk("rd data8", {56'h0, rd8}, {56'h0, x8});
            chk("rd data4", {56'h0, rd4}, {56'h0, x4});
            chk("rd held8", {56'h0, uio_out8}, {56'h0, x8});
        end else begin
            chk("wr oe idle", {56'h0, uio_oe8 | uio_oe4}, 64'h0);
        end
        held_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (!ack8 || !ack4) held_ok = 1'b0;
        end
        if (hold > 0) chk("ack held", {63'h0, held_ok}, 64'd1);
        @(negedge clk);
        ui_in[7] = 1'b0;
        rel_lat = -1;
        prev_oe = uio_oe8;
        for (int k = 1; k <= 12 && rel_lat < 0; k++) begin
            @(posedge clk); #1;
            if (!ack8) rel_lat = k;
            else prev_oe = uio_oe8;
        end
        chk("release latency", 64'(rel_lat), 64'd3);
        chk("release pins", {uio_oe8, uio_out8, uio_oe4, uio_out4, 7'h0, ack4}, 64'h0);
        if (!rw) chk("oe until release", {56'h0, prev_oe}, 64'hFF);
        if (rw) begin
            m8[a] = d;
            if (a < 4) m4[a[1:0]] = d;
            else       e4 = 1'b1;
        end else if (a >= 4) begin
            e4 = 1'b1;
        end
        ena = 1'b1;
        chk_state(rw ? "after wr" : "after rd");
    endtask

    initial begin
        logic [7:0] r8, r4;
        int lat;
        bit stay_low;

        tbl[0] = '{1'b1, 3'd3, 8'hA5, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 3'd3, 8'h00, 8'hA5, 8'hA5, 1'b0};
        tbl[2] = '{1'b1, 3'd6, 8'h3C, 8'h00, 8'h00, 1'b1};
        tbl[3] = '{1'b0, 3'd6, 8'h00, 8'h3C, 8'h00, 1'b1};
        tbl[4] = '{1'b1, 3'd1, 8'h5A, 8'h00, 8'h00, 1'b1};
        tbl[5] = '{1'b0, 3'd1, 8'h00, 8'h5A, 8'h5A, 1'b1};
        tbl[6] = '{1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1};
        tbl[7] = '{1'b1, 3'd0, 8'hFF, 8'h00, 8'h00, 1'b1};
        tbl[8] = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'hFF, 1'b1};

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset pins", {uio_oe8, uio_out8, uio_oe4, uio_out4, 6'h0, ack8, ack4}, 64'h0);
        chk_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_txn(tbl[i].rw, tbl[i].addr, tbl[i].data, 0, 1'b0, r8, r4);
            if (!tbl[i].rw) begin
                chk("tbl rd8", {56'h0, r8}, {56'h0, tbl[i].exp8});
                chk("tbl rd4", {56'h0, r4}, {56'h0, tbl[i].exp4});
            end
            chk("tbl err4", {63'h0, err4}, {63'h0, tbl[i].experr4});
        end
        chk("byte3 A5", {56'h0, regs_flat8[31:24]}, 64'hA5);

        // req held long after ack: still one transaction, ack stays up
        do_txn(1'b1, 3'd2, 8'h11, 20, 1'b0, r8, r4);

        // ena low holds off a pending request until it rises
        @(negedge clk);
        ena    = 1'b0;
        ui_in  = {1'b1, 1'b1, 3'b000, 3'd5};
        uio_in = 8'h77;
        stay_low = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack8 || ack4) stay_low = 1'b0;
        end
        chk("ena low no ack", {63'h0, stay_low}, 64'd1);
        @(negedge clk);
        ena = 1'b1;
        lat = -1;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (ack8) lat = k;
        end
        chk("ena rise ack", 64'(lat), 64'd1);
        @(negedge clk);
        ui_in[7] = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (!ack8) lat = k;
        end
        chk("ena release", 64'(lat), 64'd3);
        m8[5] = 8'h77;
        e4 = 1'b1;
        chk_state("ena seq");

        for (int n = 0; n < 40; n++) begin
            logic rw;
            logic [2:0] a;
            logic [7:0] d;
            rw = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            do_txn(rw, a, d, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), r8, r4);
        end

        // asynchronous reset while a read waits for req to drop
        @(negedge clk);
        ui_in = {1'b1, 1'b0, 3'b000, 3'd3};
        lat = -1;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (ack8) lat = k;
        end
        chk("pre-reset ack", 64'(lat), 64'd4);
        chk("pre-reset oe", {56'h0, uio_oe8}, 64'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async reset pins", {uio_oe8, uio_out8, uio_oe4, uio_out4, 6'h0, ack8, ack4}, 64'h0);
        chk_state("async reset");
        ui_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1'b0, 3'd3, 8'h00, 0, 1'b0, r8, r4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
